// File: rtl/tiny_dnn_conv_seq_pkg.sv
// Shared types and constants for the tiny-dnn convolution sequencer.
package tiny_dnn_ex_pkg;

    typedef enum logic {
        MODE_FWD = 1'b0,
        MODE_BWD = 1'b1
    } mode_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_KINIT,
        ST_EXEC,
        ST_KFIN,
        ST_WAIT,
        ST_DRAIN
    } state_e;

    // Cycles between the last k_fin and the earliest possible done.
    localparam int DRAIN_LEN = 3;

endpackage

// File: rtl/tiny_dnn_conv_seq_if.sv
// Control/config/address bundle between the layer controller and the sequencer.
interface tiny_dnn_conv_seq_if #(
    parameter int DW  = 4,
    parameter int SW  = 5,
    parameter int IAW = 12,
    parameter int WAW = 10
);
    logic           mode, start, out_busy, out_hold;
    logic [DW-1:0]  dd, id;
    logic [SW-1:0]  ih, iw, oh, ow, kh, kw, pad;
    logic [IAW-1:0] is;
    logic [WAW-1:0] ks;
    logic [2:0]     stride;
    logic           busy, k_init, exec, k_fin, done;
    logic [IAW-1:0] ia;
    logic [WAW-1:0] wa;

    modport master (
        output mode, start, out_busy, out_hold, dd, id, ih, iw, oh, ow, kh, kw,
               pad, is, ks, stride,
        input  busy, k_init, exec, k_fin, done, ia, wa
    );

    modport slave (
        input  mode, start, out_busy, out_hold, dd, id, ih, iw, oh, ow, kh, kw,
               pad, is, ks, stride,
        output busy, k_init, exec, k_fin, done, ia, wa
    );
endinterface

// File: rtl/tiny_dnn_conv_seq_loop_cnt.sv
// One nested-loop counter: runs ini..fin inclusive and wraps back to ini.
// 'next' exposes the value the counter takes at the coming edge.
module loop_cnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] ini,
    input  logic [W-1:0] fin,
    input  logic         start,
    input  logic         en,
    output logic         last,
    output logic [W-1:0] next,
    output logic [W-1:0] q
);
    assign last = (q == fin);

    // Start has priority over stepping; stepping past fin wraps to ini.
    always_comb begin
        next = q;
        if (start)
            next = ini;
        else if (en)
            next = last ? ini : q + W'(1);
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst)
            q <= '0;
        else
            q <= next;
    end
endmodule

// File: rtl/tiny_dnn_conv_seq.sv
// Convolution sequencer: walks output points and, per point, the clipped
// channel x kernel window, emitting input/weight addresses and framing strobes.
module tiny_dnn_conv_seq
    import tiny_dnn_ex_pkg::*;
#(
    parameter int DW  = 4,
    parameter int SW  = 5,
    parameter int IAW = 12,
    parameter int WAW = 10
) (
    input  logic               clk,
    input  logic               rst,
    tiny_dnn_conv_seq_if.slave bus
);
    localparam int         PW        = SW + 2;
    localparam logic [1:0] DRAIN_END = 2'(DRAIN_LEN);

    state_e         state, state_n;
    mode_e          c_mode;
    logic [DW-1:0]  c_dd, c_id;
    logic [SW-1:0]  c_ih, c_iw, c_oh, c_ow, c_kh, c_kw, c_pad;
    logic [IAW-1:0] c_is;
    logic [WAW-1:0] c_ks;
    logic [2:0]     c_stride;
    logic           go;

    assign go = (state == ST_IDLE) && bus.start;

    // Configuration is captured once per layer so mid-layer input changes are harmless.
    always_ff @(posedge clk) begin
        if (rst) begin
            c_mode <= MODE_FWD;
            c_dd <= '0; c_id <= '0;
            c_ih <= '0; c_iw <= '0; c_oh <= '0; c_ow <= '0;
            c_kh <= '0; c_kw <= '0; c_pad <= '0;
            c_is <= '0; c_ks <= '0; c_stride <= '0;
        end else if (go) begin
            c_mode <= mode_e'(bus.mode);
            c_dd <= bus.dd; c_id <= bus.id;
            c_ih <= bus.ih; c_iw <= bus.iw; c_oh <= bus.oh; c_ow <= bus.ow;
            c_kh <= bus.kh; c_kw <= bus.kw; c_pad <= bus.pad;
            c_is <= bus.is; c_ks <= bus.ks; c_stride <= bus.stride;
        end
    end

    // Loop counters: outer (dc, oy, ox) step on k_fin, inner (ic, fy, fx) on exec.
    logic [DW-1:0] dc_q, ic_n, unused_dc_n, unused_ic_q;
    logic [SW-1:0] oy_q, ox_q, fy_n, fx_n;
    logic [SW-1:0] unused_oy_n, unused_ox_n, unused_fy_q, unused_fx_q;
    logic          dc_last, oy_last, ox_last, ic_last, fy_last, fx_last;
    logic          outer_last, inner_last;
    logic          in_kfin, in_kinit, in_exec;
    logic signed [PW-1:0] yy, xx, sy, ey, sx, ex, kh_s, kw_s, y_room, x_room;
    logic          empty;

    assign in_kfin    = (state == ST_KFIN);
    assign in_kinit   = (state == ST_KINIT);
    assign in_exec    = (state == ST_EXEC);
    assign outer_last = dc_last && oy_last && ox_last;
    assign inner_last = ic_last && fy_last && fx_last;

    loop_cnt #(.W(DW)) u_dc (.clk(clk), .rst(rst), .ini('0), .fin(c_dd), .start(go),
        .en(in_kfin && ox_last && oy_last), .last(dc_last), .next(unused_dc_n), .q(dc_q));
    loop_cnt #(.W(SW)) u_oy (.clk(clk), .rst(rst), .ini('0), .fin(c_oh), .start(go),
        .en(in_kfin && ox_last), .last(oy_last), .next(unused_oy_n), .q(oy_q));
    loop_cnt #(.W(SW)) u_ox (.clk(clk), .rst(rst), .ini('0), .fin(c_ow), .start(go),
        .en(in_kfin), .last(ox_last), .next(unused_ox_n), .q(ox_q));
    loop_cnt #(.W(DW)) u_ic (.clk(clk), .rst(rst), .ini('0), .fin(c_id), .start(in_kinit),
        .en(in_exec && fx_last && fy_last), .last(ic_last), .next(ic_n), .q(unused_ic_q));
    loop_cnt #(.W(SW)) u_fy (.clk(clk), .rst(rst), .ini(SW'(sy)), .fin(SW'(ey)), .start(in_kinit),
        .en(in_exec && fx_last), .last(fy_last), .next(fy_n), .q(unused_fy_q));
    loop_cnt #(.W(SW)) u_fx (.clk(clk), .rst(rst), .ini(SW'(sx)), .fin(SW'(ex)), .start(in_kinit),
        .en(in_exec), .last(fx_last), .next(fx_n), .q(unused_fx_q));

    // Base row/column of the current output point and the kernel window clipped to the input.
    always_comb begin
        kh_s = PW'(c_kh);
        kw_s = PW'(c_kw);
        if (c_mode == MODE_BWD) begin
            yy = PW'(oy_q) - kh_s;
            xx = PW'(ox_q) - kw_s;
        end else begin
            yy = PW'(oy_q) * PW'(c_stride) - PW'(c_pad);
            xx = PW'(ox_q) * PW'(c_stride) - PW'(c_pad);
        end
        y_room = PW'(c_ih) - yy;
        x_room = PW'(c_iw) - xx;
        sy     = yy[PW-1] ? -yy : '0;
        sx     = xx[PW-1] ? -xx : '0;
        ey     = (y_room < kh_s) ? y_room : kh_s;
        ex     = (x_room < kw_s) ? x_room : kw_s;
        empty  = (sy > ey) || (sx > ex);
    end

    // Addresses for the element the inner counters move to at the coming edge.
    logic [31:0]    yy32, xx32;
    logic [IAW-1:0] ia_nx;
    logic [WAW-1:0] wa_nx;
    always_comb begin
        yy32  = {{(32-PW){yy[PW-1]}}, yy};
        xx32  = {{(32-PW){xx[PW-1]}}, xx};
        ia_nx = IAW'((32'(dc_q) + 32'(ic_n)) * 32'(c_is)
                     + (yy32 + 32'(fy_n)) * (32'(c_iw) + 32'd1)
                     + xx32 + 32'(fx_n));
        wa_nx = WAW'(32'(ic_n) * (32'(c_ks) + 32'd1)
                     + 32'(fy_n) * (32'(c_kw) + 32'd1)
                     + 32'(fx_n));
    end

    logic [1:0] drain_cnt;
    logic       done_now;
    assign done_now = (state == ST_DRAIN) && (drain_cnt == DRAIN_END) && !bus.out_hold;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_n;
    end

    // Next-state logic; an empty window goes straight from KINIT to KFIN.
    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE:  if (bus.start) state_n = ST_KINIT;
            ST_KINIT: state_n = empty ? ST_KFIN : ST_EXEC;
            ST_EXEC:  if (inner_last) state_n = ST_KFIN;
            ST_KFIN:  begin
                if (outer_last)        state_n = ST_DRAIN;
                else if (bus.out_busy) state_n = ST_WAIT;
                else                   state_n = ST_KINIT;
            end
            ST_WAIT:  if (!bus.out_busy) state_n = ST_KINIT;
            ST_DRAIN: if (done_now) state_n = ST_IDLE;
            default:  state_n = ST_IDLE;
        endcase
    end

    // Drain counter saturates at DRAIN_END and waits there for out_hold to clear.
    always_ff @(posedge clk) begin
        if (rst || state != ST_DRAIN)
            drain_cnt <= '0;
        else if (drain_cnt != DRAIN_END)
            drain_cnt <= drain_cnt + 2'd1;
    end

    // Address registers load only ahead of exec cycles, so they hold between points.
    logic           exec_q;
    logic [IAW-1:0] ia_q;
    logic [WAW-1:0] wa_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            exec_q <= 1'b0;
            ia_q   <= '0;
            wa_q   <= '0;
        end else begin
            exec_q <= (state_n == ST_EXEC);
            if (state_n == ST_EXEC) begin
                ia_q <= ia_nx;
                wa_q <= wa_nx;
            end
        end
    end

    assign bus.busy   = (state != ST_IDLE);
    assign bus.k_init = in_kinit;
    assign bus.k_fin  = in_kfin;
    assign bus.done   = done_now;
    assign bus.exec   = exec_q;
    assign bus.ia     = ia_q;
    assign bus.wa     = wa_q;
endmodule

// File: doc/tiny_dnn_conv_seq.md
# tiny_dnn_conv_seq

Parametrised convolution sequencer for the tiny-dnn MNIST accelerator. It walks output depth, output rows, output columns and, per output point, the input-channel × kernel window, and emits input-buffer and weight-buffer addresses plus kernel framing strobes to the MAC array. It supports the forward pass with runtime stride and zero-padding and the backprop (full-correlation) pass with window clipping. It replaces the fixed-width forward/backprop controller.

## Interface
- `DW`, default 4: width of the depth/channel counters (`dd`, `id`).
- `SW`, default 5: width of the spatial counters and dimensions.
- `IAW`, default 12: input address width.
- `WAW`, default 10: weight address width.
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `mode` in 1: 0 = forward, 1 = backprop; sampled at `start`.
- `start` in 1: one-cycle pulse that begins a layer; ignored unless idle.
- `out_busy` in 1: downstream is not ready for the next output point.
- `out_hold` in 1: defers `done`.
- `dd`, `id` in DW: last output-depth index and last input-channel index (inclusive).
- `ih`, `iw`, `oh`, `ow`, `kh`, `kw` in SW: last input, output and kernel row/column index (inclusive).
- `is` in IAW: input channel plane size.
- `ks` in WAW: last kernel-plane index.
- `stride` in 3: forward stride, 1..7.
- `pad` in SW: forward zero-pad.
- `busy` out 1: a layer is in progress.
- `k_init` out 1: pulse that starts an output point.
- `exec` out 1: `ia`/`wa` valid.
- `k_fin` out 1: pulse that ends an output point.
- `done` out 1: pulse that ends the layer.
- `ia` out IAW: input address.
- `wa` out WAW: weight address.

## Operation
- FSM states: IDLE → KINIT → EXEC → KFIN → (WAIT | KINIT | DRAIN) → IDLE.
- Outer loop order, slowest first: `dc` 0..`dd`, `oy` 0..`oh`, `ox` 0..`ox`'s bound `ow`.
- Inner loop order: `ic` 0..`id`, `fy` `sy`..`ey`, `fx` `sx`..`ex`.
- All bounds are inclusive.
- All configuration inputs are latched at `start`. Changes during the layer have no effect.
- Base row, signed SW+2 bits:
  - Forward: `yy = oy*stride − pad`.
  - Backprop: `yy = oy − kh`.
- Row clipping: `sy = max(0, −yy)`, `ey = min(kh, ih − yy)`.
- Columns use the same rule (`xx`, `sx`, `ex`) with `ox`, `iw`, `kw`.
- Empty window (`sy > ey` or `sx > ex`):
  - KINIT and KFIN are still issued.
  - There are zero `exec` cycles.
- Address formulas:
  - `ia = (dc+ic)*is + (yy+fy)*(iw+1) + (xx+fx)`
  - `wa = ic*(ks+1) + fy*(kw+1) + fx`
  - Both are computed at full precision and truncated modulo 2^IAW / 2^WAW.
- WAIT: after KFIN with points remaining, if `out_busy` is high, stay in WAIT until it is low, then go to KINIT.
- DRAIN: after the last point's KFIN, count 3 cycles, then assert `done`.
  - While `out_hold` is high, `done` stays pending.
  - `done` pulses on the first cycle `out_hold` is low, then the FSM returns to IDLE.
- `start` while `busy` is ignored.
- `rst` at any point:
  - Next cycle the FSM is in IDLE and all counters are 0.
  - No stray `k_fin`/`done` is produced.

## Timing
- Reset values: `busy`, `k_init`, `exec`, `k_fin`, `done` = 0; `ia`, `wa` = 0.
- `start` sampled high in cycle 0:
  - `busy` and `k_init` are high in cycle 1.
  - `exec` is high in cycles 2..N+1, where N = (`id`+1)(`ey`−`sy`+1)(`ex`−`sx`+1).
  - `k_fin` is high in cycle N+2.
- Next point: `k_init` at N+3 if `out_busy` is low in cycle N+2.
- `ia`/`wa` are registered and valid exactly on `exec` cycles. Otherwise they hold their last value.
- Last point: `k_fin` at cycle T, `done` at T+4 if `out_hold` is low, and `busy` drops at T+5.
- `k_init`, `k_fin` and `done` are never high in the same cycle.

## Structure
- Package `tiny_dnn_ex_pkg` holds:
  - the mode enum (`MODE_FWD`, `MODE_BWD`);
  - the FSM state enum;
  - the DRAIN length constant (3).
- Sub-module `loop_cnt #(W)` provides one reusable counter with `ini`/`fin`/`start`/`en`/`last`/`next`.
  - Instantiated six times.
  - `fy`/`fx` take runtime `ini` from the clipping logic.

## Test plan
- Forward, `dd`=0, `id`=0, `oh`=`ow`=1, `kh`=`kw`=1, `stride`=1, `pad`=0, `iw`=2: 4 points, each with 4 `exec` cycles. First point `ia` = 0,1,3,4 and `wa` = 0,1,2,3. `done` comes 4 cycles after the last `k_fin`.
- Forward, `stride`=2, `pad`=1, `ih`=`iw`=3, `kh`=`kw`=2, `oh`=`ow`=1: point (0,0) is clipped to 4 `exec` cycles with first `ia`=0 and `wa`=4. Point (1,1) has 9 `exec` cycles starting `ia`=5.
- Backprop, `ih`=`iw`=2, `kh`=`kw`=1, `oh`=`ow`=3: point (0,0) has a single `exec` with `ia`=0 and `wa`=3. Point (3,3) has a single `exec` with `ia`=8 and `wa`=0.
- `out_busy` held high for 5 cycles after the first `k_fin`: `k_init` is delayed until the cycle after `out_busy` falls, with no `exec` in between.
- `out_hold` high across DRAIN for 10 cycles: `done` pulses once, in the first low cycle. A `start` pulse while `busy` causes no restart.
- `rst` pulsed mid-EXEC: outputs are 0 next cycle, and a new `start` then reproduces the first scenario exactly.
